// File: rtl/sdram_wt_cache.sv
// Direct-mapped, write-through, one-word-per-line cache in front of the SDRAM controller.
// Read hits complete in two cycles; misses and every write go to the controller one at a time.
module sdram_wt_cache #(
  parameter int LINES  = 256,
  parameter int ADDR_W = 25
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wmask,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  input  logic              flush,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic [3:0]        mem_wmask,
  output logic              mem_valid,
  input  logic [31:0]       mem_dout,
  input  logic              mem_ready
);
  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX - 2;
  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_LOOKUP  = 3'd2,
    S_MISS_RD = 3'd3,
    S_WR_THRU = 3'd4
  } state_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_w[8*b +: 8];
      else         res[8*b +: 8] = old_w[8*b +: 8];
    end
    return res;
  endfunction

  state_e            state_q, state_d;
  logic [IDX-1:0]    clr_idx_q, clr_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_din_q, mem_din_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic              busy_q, busy_d;

  logic              valid_ram [LINES];
  logic [TAG_W-1:0]  tag_ram   [LINES];
  logic [31:0]       data_ram  [LINES];
  logic              rd_valid_q;
  logic [TAG_W-1:0]  rd_tag_q;
  logic [31:0]       rd_data_q;
  logic              ram_we_s;
  logic [IDX-1:0]    ram_widx_s;
  logic              ram_wvalid_s;
  logic [TAG_W-1:0]  ram_wtag_s;
  logic [31:0]       ram_wdata_s;
  logic              line_hit_s;

  assign line_hit_s = rd_valid_q && (rd_tag_q == addr_q[ADDR_W-1:IDX+2]);

  // Line storage: synchronous read, captured only while idle so LOOKUP sees the accepted index.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      valid_ram[ram_widx_s] <= ram_wvalid_s;
      tag_ram[ram_widx_s]   <= ram_wtag_s;
      data_ram[ram_widx_s]  <= ram_wdata_s;
    end
    if (state_q == S_IDLE) begin
      rd_valid_q <= valid_ram[cpu_addr[IDX+1:2]];
      rd_tag_q   <= tag_ram[cpu_addr[IDX+1:2]];
      rd_data_q  <= data_ram[cpu_addr[IDX+1:2]];
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    cpu_ready_d  = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    mem_wmask_d  = mem_wmask_q;
    ram_we_s     = 1'b0;
    ram_widx_s   = clr_idx_q;
    ram_wvalid_s = 1'b0;
    ram_wtag_s   = {TAG_W{1'b0}};
    ram_wdata_s  = 32'd0;
    case (state_q)
      S_INIT: begin
        ram_we_s = 1'b1;
        if (clr_idx_q == {IDX{1'b1}}) begin
          state_d = S_IDLE;
        end else begin
          clr_idx_d = clr_idx_q + {{(IDX-1){1'b0}}, 1'b1};
        end
      end
      S_IDLE: begin
        if (flush) begin
          state_d   = S_INIT;
          clr_idx_d = {IDX{1'b0}};
        end else if (cpu_valid && !cpu_ready_q) begin
          addr_d  = cpu_addr & WORD_MASK;
          wdata_d = cpu_wdata;
          wmask_d = cpu_wmask;
          state_d = S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (wmask_q != 4'b0000) begin
          mem_valid_d = 1'b1;
          mem_addr_d  = addr_q;
          mem_din_d   = wdata_q;
          mem_wmask_d = wmask_q;
          state_d     = S_WR_THRU;
          // Write hits keep the line coherent; write misses never allocate.
          if (line_hit_s) begin
            ram_we_s     = 1'b1;
            ram_widx_s   = addr_q[IDX+1:2];
            ram_wvalid_s = 1'b1;
            ram_wtag_s   = rd_tag_q;
            ram_wdata_s  = merge_bytes(rd_data_q, wdata_q, wmask_q);
          end else begin
            ram_we_s = 1'b0;
          end
        end else if (line_hit_s) begin
          cpu_ready_d = 1'b1;
          cpu_rdata_d = rd_data_q;
          state_d     = S_IDLE;
        end else begin
          mem_valid_d = 1'b1;
          mem_addr_d  = addr_q;
          mem_wmask_d = 4'b0000;
          state_d     = S_MISS_RD;
        end
      end
      S_MISS_RD: begin
        if (mem_ready) begin
          ram_we_s     = 1'b1;
          ram_widx_s   = addr_q[IDX+1:2];
          ram_wvalid_s = 1'b1;
          ram_wtag_s   = addr_q[ADDR_W-1:IDX+2];
          ram_wdata_s  = mem_dout;
          cpu_rdata_d  = mem_dout;
          cpu_ready_d  = 1'b1;
          mem_valid_d  = 1'b0;
          state_d      = S_IDLE;
        end else begin
          state_d = S_MISS_RD;
        end
      end
      S_WR_THRU: begin
        if (mem_ready) begin
          cpu_ready_d = 1'b1;
          mem_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_WR_THRU;
        end
      end
      default: begin
        state_d   = S_INIT;
        clr_idx_d = {IDX{1'b0}};
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_INIT;
      clr_idx_q   <= {IDX{1'b0}};
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= 32'd0;
      wmask_q     <= 4'd0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= 32'd0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_din_q   <= 32'd0;
      mem_wmask_q <= 4'd0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_wmask_q <= mem_wmask_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_wmask = mem_wmask_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sdram_wt_cache.sv
// Directed bench for sdram_wt_cache: vector table of CPU transactions against a small
// SDRAM responder model, plus hand-written INIT, flush and mid-miss reset sequences.
module tb_sdram_wt_cache;
  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_valid;
  logic [24:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wmask;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        flush;
  logic        busy;
  logic [24:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_wmask;
  logic        mem_valid;
  logic [31:0] mem_dout;
  logic        mem_ready;

  sdram_wt_cache #(.LINES(256), .ADDR_W(25)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wmask(cpu_wmask), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .flush(flush), .busy(busy),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wmask(mem_wmask),
    .mem_valid(mem_valid), .mem_dout(mem_dout), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // SDRAM responder: ready pulse mdelay cycles after valid is seen, byte-merged writes.
  logic [31:0] mem_model [1024];
  int          mdelay;
  int          mcnt;
  always @(posedge clk) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      mcnt      <= 0;
      mem_dout  <= 32'd0;
      for (int i = 0; i < 1024; i++)
        mem_model[i] <= (i == 64) ? 32'hDEADBEEF : (32'h5A5A0000 + 32'(i));
    end else if (mem_ready) begin
      mem_ready <= 1'b0;
    end else if (mem_valid) begin
      if (mcnt >= mdelay) begin
        mem_ready <= 1'b1;
        mcnt      <= 0;
        mem_dout  <= mem_model[mem_addr[11:2]];
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) mem_model[mem_addr[11:2]][8*b +: 8] <= mem_din[8*b +: 8];
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  int          t_cyc, t_rdy;
  logic        t_done, t_touched;
  logic [31:0] t_rdata, t_mdin;
  logic [24:0] t_maddr;
  logic [3:0]  t_mwm;

  task automatic wait_done(input string name);
    t_cyc = 0; t_rdy = -1; t_done = 1'b0; t_touched = 1'b0;
    for (int i = 0; i < 400 && !t_done; i++) begin
      @(posedge clk); #1;
      t_cyc++;
      if (mem_valid && !t_touched) begin
        t_touched = 1'b1; t_maddr = mem_addr; t_mdin = mem_din; t_mwm = mem_wmask;
      end
      if (mem_ready) t_rdy = t_cyc;
      if (cpu_ready) begin
        t_done = 1'b1; t_rdata = cpu_rdata;
      end
    end
    cpu_valid = 1'b0;
    check({name, " done"}, {31'd0, t_done}, 32'd1);
    check({name, " mem_valid low at ready"}, {31'd0, mem_valid}, 32'd0);
  endtask

  task automatic issue(input logic [24:0] a, input logic [31:0] wd, input logic [3:0] wm);
    @(posedge clk); #1;
    cpu_valid = 1'b1; cpu_addr = a; cpu_wdata = wd; cpu_wmask = wm;
  endtask

  typedef struct {
    logic [24:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          delay;
    logic        exp_mem;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[14];

  int viol;
  logic b255, b256;
  int n;

  initial begin
    vecs[0]  = '{25'h0000100, 32'h00000000, 4'b0000, 0,  1'b0, 32'hDEADBEEF};
    vecs[1]  = '{25'h0000100, 32'h11223344, 4'b0011, 2,  1'b1, 32'hDEADBEEF};
    vecs[2]  = '{25'h0000100, 32'h00000000, 4'b0000, 0,  1'b0, 32'hDEAD3344};
    vecs[3]  = '{25'h0000500, 32'hCAFEF00D, 4'b1111, 10, 1'b1, 32'hDEAD3344};
    vecs[4]  = '{25'h0000500, 32'h00000000, 4'b0000, 1,  1'b1, 32'hCAFEF00D};
    vecs[5]  = '{25'h0000100, 32'h00000000, 4'b0000, 0,  1'b1, 32'hDEAD3344};
    vecs[6]  = '{25'h0000100, 32'h00000000, 4'b0000, 0,  1'b0, 32'hDEAD3344};
    vecs[7]  = '{25'h0000500, 32'h00000000, 4'b0000, 3,  1'b1, 32'hCAFEF00D};
    vecs[8]  = '{25'h0000504, 32'h00000000, 4'b0000, 0,  1'b1, 32'h5A5A0141};
    vecs[9]  = '{25'h0000504, 32'h77000000, 4'b1000, 1,  1'b1, 32'h5A5A0141};
    vecs[10] = '{25'h0000504, 32'h00000000, 4'b0000, 0,  1'b0, 32'h775A0141};
    vecs[11] = '{25'h1FFFFFC, 32'h00000000, 4'b0000, 2,  1'b1, 32'h5A5A03FF};
    vecs[12] = '{25'h1FFFFFC, 32'h00000000, 4'b0000, 0,  1'b0, 32'h5A5A03FF};
    vecs[13] = '{25'h00003FC, 32'h00000000, 4'b0000, 0,  1'b1, 32'h5A5A00FF};

    resetn = 1'b0; flush = 1'b0; mdelay = 0;
    cpu_valid = 1'b1; cpu_addr = 25'h0000100; cpu_wdata = 32'd0; cpu_wmask = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset cpu_ready", {31'd0, cpu_ready}, 32'd0);
    check("reset cpu_rdata", cpu_rdata, 32'd0);
    check("reset mem_valid", {31'd0, mem_valid}, 32'd0);
    check("reset mem_addr", {7'd0, mem_addr}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd1);
    resetn = 1'b1;

    // INIT must ignore the held request for exactly 256 cycles.
    viol = 0; b255 = 1'b0; b256 = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      @(posedge clk); #1;
      if (cpu_ready || mem_valid) viol++;
      if (i == 255) b255 = busy;
      if (i == 256) b256 = busy;
    end
    check("init no activity", 32'(viol), 32'd0);
    check("init busy at 255", {31'd0, b255}, 32'd1);
    check("init busy at 256", {31'd0, b256}, 32'd0);
    wait_done("first miss");
    check("first miss rdata", t_rdata, 32'hDEADBEEF);
    check("first miss mem used", {31'd0, t_touched}, 32'd1);
    check("first miss mem_addr", {7'd0, t_maddr}, 32'h00000100);
    check("first miss mem_wmask", {28'd0, t_mwm}, 32'd0);
    check("first miss ready gap", 32'(t_cyc - t_rdy), 32'd1);

    for (int v = 0; v < 14; v++) begin
      mdelay = vecs[v].delay;
      issue(vecs[v].addr, vecs[v].wdata, vecs[v].wmask);
      wait_done($sformatf("v%0d", v));
      check($sformatf("v%0d rdata", v), t_rdata, vecs[v].exp_rdata);
      check($sformatf("v%0d mem used", v), {31'd0, t_touched}, {31'd0, vecs[v].exp_mem});
      if (vecs[v].exp_mem) begin
        check($sformatf("v%0d mem_addr", v), {7'd0, t_maddr}, {7'd0, vecs[v].addr & 25'h1FFFFFC});
        check($sformatf("v%0d mem_wmask", v), {28'd0, t_mwm}, {28'd0, vecs[v].wmask});
        check($sformatf("v%0d ready gap", v), 32'(t_cyc - t_rdy), 32'd1);
        if (vecs[v].wmask != 4'b0000)
          check($sformatf("v%0d mem_din", v), t_mdin, vecs[v].wdata);
      end else begin
        check($sformatf("v%0d hit latency", v), 32'(t_cyc), 32'd2);
      end
    end

    // Flush: busy for the full INIT sweep, then previously cached lines miss.
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd1);
    n = 0;
    for (int i = 0; i < 400 && busy; i++) begin
      @(posedge clk); #1;
      n++;
    end
    check("flush init length", 32'(n), 32'd256);
    mdelay = 0;
    issue(25'h0000504, 32'd0, 4'b0000);
    wait_done("post flush");
    check("post flush mem used", {31'd0, t_touched}, 32'd1);
    check("post flush rdata", t_rdata, 32'h775A0141);

    // Reset in the middle of a miss.
    mdelay = 20;
    issue(25'h0000100, 32'd0, 4'b0000);
    for (int i = 0; i < 20 && !mem_valid; i++) begin
      @(posedge clk); #1;
    end
    check("rst pre mem_valid", {31'd0, mem_valid}, 32'd1);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("rst mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd1);
    viol = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (cpu_ready || mem_valid) viol++;
    end
    check("rst no activity", 32'(viol), 32'd0);
    cpu_valid = 1'b0;
    resetn = 1'b1;
    for (int i = 0; i < 400 && busy; i++) begin
      @(posedge clk); #1;
      if (cpu_ready) viol++;
    end
    check("rst reinit busy", {31'd0, busy}, 32'd0);
    check("rst reinit no ready", 32'(viol), 32'd0);
    mdelay = 0;
    issue(25'h0000100, 32'd0, 4'b0000);
    wait_done("after reset");
    check("after reset mem used", {31'd0, t_touched}, 32'd1);
    check("after reset rdata", t_rdata, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
